// File: rtl/debug_unit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : debug_unit_ctrl
//  Brief    : Host-side debug initiator. Decodes UART command bytes, loads
//             program words into instruction memory, runs or single-steps
//             the pipeline, then streams PC, registers, data memory and the
//             cycle count back out through the UART transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
module debug_unit_ctrl #(
  parameter int NB_DATA     = 32,
  parameter int NB_ADDR     = 7,
  parameter int NB_REG      = 5,
  parameter int N_REGISTER  = 32,
  parameter int N_MEM_WORDS = 32,
  parameter int N_BYTES     = 4
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_done,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_inst_load,
  output logic [NB_ADDR-1:0] o_addr_inst_load,
  output logic               o_en_write,
  output logic               o_en_read,
  output logic               o_debug_unit,
  output logic               o_enable_pipe,
  output logic [NB_REG-1:0]  o_addr_reg,
  output logic               o_ctrl_read_reg,
  output logic [NB_ADDR-1:0] o_addr_mem,
  output logic               o_ctrl_mem,
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic [NB_DATA-1:0] i_data_reg,
  input  logic [NB_DATA-1:0] i_data_mem,
  input  logic [NB_ADDR-1:0] i_count_cycles,
  input  logic               i_halt,
  output logic [3:0]         o_state
);

  // Dump word index: 0 = PC, then registers, then memory words, last = cycles
  localparam int NB_BCNT = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int N_WORDS = N_REGISTER + N_MEM_WORDS + 2;
  localparam int NB_IDX  = $clog2(N_WORDS);

  localparam logic [NB_BCNT-1:0] BYTE_LAST     = NB_BCNT'(N_BYTES - 1);
  localparam logic [NB_IDX-1:0]  IDX_REG_FIRST = NB_IDX'(1);
  localparam logic [NB_IDX-1:0]  IDX_MEM_FIRST = NB_IDX'(N_REGISTER + 1);
  localparam logic [NB_IDX-1:0]  IDX_LAST      = NB_IDX'(N_WORDS - 1);

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_STEP = 8'h03;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LOAD_BYTE  = 4'd1,
    LOAD_WRITE = 4'd2,
    RUN        = 4'd3,
    STEP       = 4'd4,
    STEP_WAIT  = 4'd5,
    DUMP_READ  = 4'd6,
    DUMP_LATCH = 4'd7,
    DUMP_SEND  = 4'd8,
    DUMP_WAIT  = 4'd9
  } state_t;

  state_t              state;
  logic [NB_BCNT-1:0]  byte_cnt;
  logic [NB_DATA-1:0]  load_word;
  logic [NB_ADDR-1:0]  load_addr;
  logic                halted;
  logic [NB_IDX-1:0]   word_idx;
  logic [NB_DATA-1:0]  tx_word;

  logic [NB_IDX-1:0]   next_idx;
  logic [NB_IDX-1:0]   reg_off;
  logic [NB_IDX-1:0]   mem_off;
  logic                next_is_reg;
  logic                next_is_mem;
  logic                cur_is_reg;
  logic                cur_is_mem;

  assign o_state = state;

  // Classify the current and the following dump word and derive read addresses
  always_comb begin
    next_idx    = word_idx + IDX_REG_FIRST;
    reg_off     = next_idx - IDX_REG_FIRST;
    mem_off     = next_idx - IDX_MEM_FIRST;
    next_is_reg = (next_idx < IDX_MEM_FIRST);
    next_is_mem = (next_idx >= IDX_MEM_FIRST) && (next_idx != IDX_LAST);
    cur_is_reg  = (word_idx != '0) && (word_idx < IDX_MEM_FIRST);
    cur_is_mem  = (word_idx >= IDX_MEM_FIRST) && (word_idx != IDX_LAST);
  end

  // Command decoder, loader, run/step control and dump sequencer
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state            <= IDLE;
      byte_cnt         <= '0;
      load_word        <= '0;
      load_addr        <= '0;
      halted           <= 1'b0;
      word_idx         <= '0;
      tx_word          <= '0;
      o_tx_data        <= '0;
      o_tx_start       <= 1'b0;
      o_inst_load      <= '0;
      o_addr_inst_load <= '0;
      o_en_write       <= 1'b0;
      o_en_read        <= 1'b1;
      o_debug_unit     <= 1'b0;
      o_enable_pipe    <= 1'b0;
      o_addr_reg       <= '0;
      o_ctrl_read_reg  <= 1'b0;
      o_addr_mem       <= '0;
      o_ctrl_mem       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD: begin
                state        <= LOAD_BYTE;
                byte_cnt     <= '0;
                o_debug_unit <= 1'b1;
                o_en_read    <= 1'b0;
              end
              CMD_RUN: begin
                // A halt already visible at command time means nothing to run
                if (halted || i_halt) begin
                  halted   <= 1'b1;
                  word_idx <= '0;
                  state    <= DUMP_READ;
                end else begin
                  o_enable_pipe <= 1'b1;
                  state         <= RUN;
                end
              end
              CMD_STEP: begin
                if (halted) begin
                  word_idx <= '0;
                  state    <= DUMP_READ;
                end else begin
                  o_enable_pipe <= 1'b1;
                  state         <= STEP;
                end
              end
              default: ;
            endcase
          end
        end
        LOAD_BYTE: begin
          if (i_rx_valid) begin
            load_word <= {load_word[NB_DATA-9:0], i_rx_data};
            if (byte_cnt == BYTE_LAST) begin
              byte_cnt         <= '0;
              o_inst_load      <= {load_word[NB_DATA-9:0], i_rx_data};
              o_addr_inst_load <= load_addr;
              o_en_write       <= 1'b1;
              state            <= LOAD_WRITE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        LOAD_WRITE: begin
          o_en_write <= 1'b0;
          // The all-ones HALT word is written like any other and closes the load
          if (o_inst_load == '1) begin
            load_addr    <= '0;
            halted       <= 1'b0;
            o_debug_unit <= 1'b0;
            o_en_read    <= 1'b1;
            state        <= IDLE;
          end else begin
            load_addr <= load_addr + NB_ADDR'(N_BYTES);
            state     <= LOAD_BYTE;
          end
        end
        RUN: begin
          if (i_halt) begin
            o_enable_pipe <= 1'b0;
            halted        <= 1'b1;
            word_idx      <= '0;
            state         <= DUMP_READ;
          end
        end
        STEP: begin
          o_enable_pipe <= 1'b0;
          state         <= STEP_WAIT;
        end
        STEP_WAIT: begin
          if (i_halt) begin
            halted <= 1'b1;
          end
          word_idx <= '0;
          state    <= DUMP_READ;
        end
        DUMP_READ: begin
          // Request was presented on entry; memory samples it this cycle
          o_ctrl_read_reg <= 1'b0;
          o_ctrl_mem      <= 1'b0;
          state           <= DUMP_LATCH;
        end
        DUMP_LATCH: begin
          if (word_idx == '0) begin
            tx_word <= NB_DATA'(i_pc);
          end else if (cur_is_reg) begin
            tx_word <= i_data_reg;
          end else if (cur_is_mem) begin
            tx_word <= i_data_mem;
          end else begin
            tx_word <= NB_DATA'(i_count_cycles);
          end
          byte_cnt <= '0;
          state    <= DUMP_SEND;
        end
        DUMP_SEND: begin
          o_tx_data  <= tx_word[NB_DATA-1 -: 8];
          o_tx_start <= 1'b1;
          state      <= DUMP_WAIT;
        end
        DUMP_WAIT: begin
          o_tx_start <= 1'b0;
          // A done coincident with our own start strobe cannot belong to this byte
          if (i_tx_done && !o_tx_start) begin
            if (byte_cnt == BYTE_LAST) begin
              if (word_idx == IDX_LAST) begin
                state <= IDLE;
              end else begin
                word_idx        <= next_idx;
                o_ctrl_read_reg <= next_is_reg;
                o_ctrl_mem      <= next_is_mem;
                if (next_is_reg) begin
                  o_addr_reg <= NB_REG'(reg_off);
                end
                if (next_is_mem) begin
                  o_addr_mem <= NB_ADDR'({mem_off, 2'b00});
                end
                state <= DUMP_READ;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              tx_word  <= tx_word << 8;
              state    <= DUMP_SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debug_unit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debug_unit_ctrl
//  Brief    : Self-checking bench for debug_unit_ctrl with UART, register
//             file and data memory models and a reference dump builder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_debug_unit_ctrl;

  localparam int DUMP_LEN = 264;

  logic        clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        i_tx_done = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic [31:0] o_inst_load;
  logic [6:0]  o_addr_inst_load;
  logic        o_en_write, o_en_read, o_debug_unit, o_enable_pipe;
  logic [4:0]  o_addr_reg;
  logic        o_ctrl_read_reg;
  logic [6:0]  o_addr_mem;
  logic        o_ctrl_mem;
  logic [6:0]  i_pc = 7'd0;
  logic [31:0] i_data_reg = 32'd0;
  logic [31:0] i_data_mem = 32'd0;
  logic [6:0]  i_count_cycles = 7'd0;
  logic        i_halt = 1'b0;
  logic [3:0]  o_state;

  debug_unit_ctrl dut (
    .clock(clock), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_tx_done(i_tx_done), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_inst_load(o_inst_load), .o_addr_inst_load(o_addr_inst_load), .o_en_write(o_en_write),
    .o_en_read(o_en_read), .o_debug_unit(o_debug_unit), .o_enable_pipe(o_enable_pipe),
    .o_addr_reg(o_addr_reg), .o_ctrl_read_reg(o_ctrl_read_reg), .o_addr_mem(o_addr_mem),
    .o_ctrl_mem(o_ctrl_mem), .i_pc(i_pc), .i_data_reg(i_data_reg), .i_data_mem(i_data_mem),
    .i_count_cycles(i_count_cycles), .i_halt(i_halt), .o_state(o_state)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [31:0] regs [32];
  logic [31:0] mems [32];
  logic [7:0]  tx_bytes [$];
  logic [7:0]  exp_bytes [$];
  int tx_delay = 0;
  bit tx_busy = 1'b0;
  int tx_wait = 0;
  int overlap = 0;
  int en_cnt = 0;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
    logic        dbg;
  } wr_t;
  wr_t writes [$];

  // Register file and data memory: one-cycle read latency, garbage otherwise
  always @(posedge clock) begin
    if (o_ctrl_read_reg) i_data_reg <= regs[o_addr_reg];
    else                 i_data_reg <= $urandom;
    if (o_ctrl_mem)      i_data_mem <= mems[o_addr_mem[6:2]];
    else                 i_data_mem <= $urandom;
  end

  // UART transmitter model plus enable / write monitors
  always @(negedge clock) begin
    if (o_enable_pipe) en_cnt++;
    if (o_en_write) writes.push_back('{o_addr_inst_load, o_inst_load, o_debug_unit});
    i_tx_done = 1'b0;
    if (o_tx_start) begin
      if (tx_busy) overlap++;
      tx_bytes.push_back(o_tx_data);
      tx_busy = 1'b1;
      tx_wait = tx_delay;
    end else if (tx_busy) begin
      if (tx_wait == 0) begin
        i_tx_done = 1'b1;
        tx_busy   = 1'b0;
      end else begin
        tx_wait--;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge clock);
    i_rx_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_dump(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if ((tx_bytes.size() - base) >= DUMP_LEN && o_state == 4'd0 && !tx_busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  function automatic void push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_bytes.push_back(w[8*i +: 8]);
  endfunction

  // Reference frame: PC, registers, memory words, cycle count, all MSB first
  function automatic void build_expected();
    exp_bytes.delete();
    push_word({25'd0, i_pc});
    for (int r = 0; r < 32; r++) push_word(regs[r]);
    for (int m = 0; m < 32; m++) push_word(mems[m]);
    push_word({25'd0, i_count_cycles});
  endfunction

  function automatic int first_bad(input int base);
    for (int i = 0; i < DUMP_LEN; i++) begin
      if (base + i >= tx_bytes.size()) return i;
      if (tx_bytes[base + i] !== exp_bytes[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] got_at(input int idx);
    if (idx < tx_bytes.size()) return tx_bytes[idx];
    return 8'hxx;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'hFFFF_FFFF) w = 32'h1234_5678;
    return w;
  endfunction

  task automatic test_reset();
    logic [65:0] others;
    logic [31:0] w1, w2;
    int b0;
    i_reset = 1'b1;
    tick(3);
    others = {o_tx_data, o_tx_start, o_inst_load, o_addr_inst_load, o_en_write, o_debug_unit,
              o_enable_pipe, o_addr_reg, o_ctrl_read_reg, o_addr_mem, o_ctrl_mem, o_state};
    tests++;
    if (others !== '0 || o_en_read !== 1'b1) begin
      fails++;
      $display("FAIL reset_outputs got others=%h en_read=%b expected others=0 en_read=1", others, o_en_read);
    end
    i_reset = 1'b0;
    tick(2);
    // Load one word so the load address moves off zero, then abort mid-word
    w1 = rand_word();
    b0 = writes.size();
    send_byte(8'h01);
    send_word(w1);
    tests++;
    if (writes.size() != b0 + 1 || writes[b0].addr !== 7'd0 || writes[b0].data !== w1) begin
      fails++;
      $display("FAIL reset_preload_write got count=%0d expected count=1 addr=0 data=%h", writes.size() - b0, w1);
    end
    send_byte(8'hAA);
    send_byte(8'h55);
    i_reset = 1'b1;
    tick(2);
    others = {o_tx_data, o_tx_start, o_inst_load, o_addr_inst_load, o_en_write, o_debug_unit,
              o_enable_pipe, o_addr_reg, o_ctrl_read_reg, o_addr_mem, o_ctrl_mem, o_state};
    tests++;
    if (others !== '0 || o_en_read !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_load got others=%h en_read=%b expected others=0 en_read=1", others, o_en_read);
    end
    i_reset = 1'b0;
    tick(2);
    w2 = rand_word();
    b0 = writes.size();
    send_byte(8'h01);
    send_word(w2);
    send_word(32'hFFFF_FFFF);
    tick(2);
    tests++;
    if (writes.size() != b0 + 2 || writes[b0].addr !== 7'd0 || writes[b0].data !== w2) begin
      fails++;
      $display("FAIL reset_reload_addr got count=%0d addr=%0d expected count=2 addr=0", writes.size() - b0,
               (writes.size() > b0) ? writes[b0].addr : 7'h7f);
    end
  endtask

  task automatic test_load(input int n_words, input string name);
    logic [31:0] words [$];
    int b0, bad;
    words.push_back(32'h2001_0005);
    for (int i = 1; i < n_words; i++) words.push_back(rand_word());
    words.push_back(32'hFFFF_FFFF);
    b0 = writes.size();
    send_byte(8'h01);
    foreach (words[i]) send_word(words[i]);
    tick(2);
    tests++;
    if (writes.size() - b0 != words.size()) begin
      fails++;
      $display("FAIL %s_count got %0d expected %0d", name, writes.size() - b0, words.size());
    end
    bad = 0;
    for (int i = 0; i < words.size() && b0 + i < writes.size(); i++) begin
      if (writes[b0+i].addr !== 7'((4 * i) % 128) || writes[b0+i].data !== words[i] || writes[b0+i].dbg !== 1'b1) begin
        if (bad == 0)
          $display("FAIL %s_write word %0d got addr=%0d data=%h dbg=%b expected addr=%0d data=%h dbg=1", name, i,
                   writes[b0+i].addr, writes[b0+i].data, writes[b0+i].dbg, (4 * i) % 128, words[i]);
        bad++;
      end
    end
    tests++;
    if (bad != 0) fails++;
    tests++;
    if (o_state !== 4'd0 || o_debug_unit !== 1'b0 || o_en_read !== 1'b1) begin
      fails++;
      $display("FAIL %s_end got state=%0d dbg=%b en_read=%b expected state=0 dbg=0 en_read=1", name,
               o_state, o_debug_unit, o_en_read);
    end
  endtask

  task automatic test_run(input int n_run);
    int en0, b0, seen, bad;
    bit ok, reached;
    i_pc           = 7'($urandom);
    i_count_cycles = 7'($urandom);
    i_halt         = 1'b0;
    en0 = en_cnt;
    b0  = tx_bytes.size();
    i_rx_data  = 8'h02;
    i_rx_valid = 1'b1;
    @(negedge clock);
    i_rx_valid = 1'b0;
    seen = 0;
    reached = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (o_enable_pipe) seen++;
      if (seen == n_run) begin reached = 1'b1; break; end
      @(negedge clock);
    end
    i_halt = 1'b1;
    tests++;
    if (!reached) begin
      fails++;
      $display("FAIL run_enable_hold got %0d enabled cycles expected %0d before halt", seen, n_run);
    end
    build_expected();
    wait_dump(b0, 5000, ok);
    i_halt = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL run_dump_timeout got %0d bytes expected %0d", tx_bytes.size() - b0, DUMP_LEN);
    end
    tests++;
    if (en_cnt - en0 != n_run) begin
      fails++;
      $display("FAIL run_enable_cycles got %0d expected %0d", en_cnt - en0, n_run);
    end
    tests++;
    if ({got_at(b0), got_at(b0+1), got_at(b0+2), got_at(b0+3)} !== {25'd0, i_pc}) begin
      fails++;
      $display("FAIL run_pc_bytes got %h expected %h", {got_at(b0), got_at(b0+1), got_at(b0+2), got_at(b0+3)}, {25'd0, i_pc});
    end
    bad = first_bad(b0);
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL run_dump byte %0d got %h expected %h", bad, got_at(b0 + bad), exp_bytes[bad]);
    end
  endtask

  task automatic test_reset_mid_run();
    send_byte(8'h01);
    send_word(32'hFFFF_FFFF);
    i_halt = 1'b0;
    send_byte(8'h02);
    tick(3);
    tests++;
    if (o_enable_pipe !== 1'b1) begin
      fails++;
      $display("FAIL midrun_enable got %b expected 1", o_enable_pipe);
    end
    i_reset = 1'b1;
    @(negedge clock);
    tests++;
    if (o_enable_pipe !== 1'b0 || o_state !== 4'd0) begin
      fails++;
      $display("FAIL midrun_reset got enable=%b state=%0d expected enable=0 state=0", o_enable_pipe, o_state);
    end
    i_reset = 1'b0;
    tick(2);
  endtask

  task automatic test_step(input logic halt_lvl, input string name);
    int en0, b0, bad;
    bit ok;
    i_pc           = 7'($urandom);
    i_count_cycles = 7'($urandom);
    i_halt         = halt_lvl;
    en0 = en_cnt;
    b0  = tx_bytes.size();
    build_expected();
    send_byte(8'h03);
    wait_dump(b0, 5000, ok);
    i_halt = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout got %0d bytes expected %0d", name, tx_bytes.size() - b0, DUMP_LEN);
    end
    tests++;
    if (en_cnt - en0 != 1) begin
      fails++;
      $display("FAIL %s_enable got %0d cycles expected 1", name, en_cnt - en0);
    end
    tests++;
    if ({got_at(b0+260), got_at(b0+261), got_at(b0+262), got_at(b0+263)} !== {25'd0, i_count_cycles}) begin
      fails++;
      $display("FAIL %s_cycles got %h expected %h", name,
               {got_at(b0+260), got_at(b0+261), got_at(b0+262), got_at(b0+263)}, {25'd0, i_count_cycles});
    end
    bad = first_bad(b0);
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s_dump byte %0d got %h expected %h", name, bad, got_at(b0 + bad), exp_bytes[bad]);
    end
  endtask

  task automatic test_halted_and_unknown();
    int en0, b0, w0, bad;
    bit ok;
    // RUN while already halted: dump only; a LOAD byte during the dump is dropped
    en0 = en_cnt;
    b0  = tx_bytes.size();
    build_expected();
    send_byte(8'h02);
    tick(20);
    send_byte(8'h01);
    wait_dump(b0, 5000, ok);
    tick(3);
    tests++;
    if (!ok || en_cnt - en0 != 0 || o_state !== 4'd0) begin
      fails++;
      $display("FAIL halted_run got ok=%b enable=%0d state=%0d expected ok=1 enable=0 state=0", ok, en_cnt - en0, o_state);
    end
    bad = first_bad(b0);
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL halted_dump byte %0d got %h expected %h", bad, got_at(b0 + bad), exp_bytes[bad]);
    end
    // Unknown command byte
    en0 = en_cnt;
    b0  = tx_bytes.size();
    w0  = writes.size();
    send_byte(8'h7E);
    tick(20);
    tests++;
    if (o_state !== 4'd0 || tx_bytes.size() != b0 || en_cnt != en0 || writes.size() != w0) begin
      fails++;
      $display("FAIL unknown_cmd got state=%0d tx=%0d en=%0d wr=%0d expected all idle", o_state,
               tx_bytes.size() - b0, en_cnt - en0, writes.size() - w0);
    end
    // RUN arriving while i_halt is already high on a fresh program
    send_byte(8'h01);
    send_word(32'hFFFF_FFFF);
    i_halt = 1'b1;
    en0 = en_cnt;
    b0  = tx_bytes.size();
    build_expected();
    send_byte(8'h02);
    wait_dump(b0, 5000, ok);
    i_halt = 1'b0;
    bad = first_bad(b0);
    tests++;
    if (!ok || en_cnt - en0 != 0 || bad >= 0) begin
      fails++;
      $display("FAIL run_halt_same_cycle got ok=%b enable=%0d bad_byte=%0d expected ok=1 enable=0 bad_byte=-1",
               ok, en_cnt - en0, bad);
    end
  endtask

  task automatic test_slow_tx();
    int b0, bad, ov0;
    bit ok;
    regs[5]  = 32'hDEAD_BEEF;
    tx_delay = 50;
    ov0 = overlap;
    b0  = tx_bytes.size();
    build_expected();
    send_byte(8'h02);
    wait_dump(b0, DUMP_LEN * 60 + 500, ok);
    tx_delay = 0;
    tests++;
    if (!ok || overlap != ov0) begin
      fails++;
      $display("FAIL slow_tx got ok=%b overlaps=%0d expected ok=1 overlaps=0", ok, overlap - ov0);
    end
    tests++;
    if ({got_at(b0+24), got_at(b0+25), got_at(b0+26), got_at(b0+27)} !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL slow_reg5 got %h expected deadbeef", {got_at(b0+24), got_at(b0+25), got_at(b0+26), got_at(b0+27)});
    end
    bad = first_bad(b0);
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL slow_dump byte %0d got %h expected %h", bad, got_at(b0 + bad), exp_bytes[bad]);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      regs[i] = $urandom;
      mems[i] = $urandom;
    end
    @(negedge clock);
    test_reset();
    test_load(2, "load");
    test_load(33, "load_wrap");
    test_run(10);
    test_reset_mid_run();
    test_step(1'b0, "step1");
    test_step(1'b0, "step2");
    test_step(1'b1, "step_halt");
    test_halted_and_unknown();
    test_slow_tx();
    tests++;
    if (overlap != 0) begin
      fails++;
      $display("FAIL tx_overlap got %0d expected 0", overlap);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
